// File: rtl/plab2_proc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// plab2_proc_fetch_unit_if
//   Bundles every handshake and bus signal of the instruction-fetch front end:
//     F stage   : domain, pc_next_F, fetch_val_F, fetch_rdy_F, squash_F
//     imem req  : imemreq_val, imemreq_rdy, imemreq_msg_addr
//     imem resp : imemresp_val, imemresp_rdy, imemresp_msg_data
//     D stage   : inst_val_D, inst_rdy_D, inst_D, inst_domain_D
//     debug     : num_inflight
//   modport master : the fetch unit's view (drives fetch_rdy_F, the imem
//                    request, imemresp_rdy and the D-stage outputs)
//   modport slave  : the surrounding pipeline / memory view
// ---------------------------------------------------------------------------
interface plab2_proc_fetch_unit_if #(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32
);
  logic                    domain;
  logic [p_addr_nbits-1:0] pc_next_F;
  logic                    fetch_val_F;
  logic                    fetch_rdy_F;
  logic                    squash_F;
  logic                    imemreq_val;
  logic                    imemreq_rdy;
  logic [p_addr_nbits-1:0] imemreq_msg_addr;
  logic                    imemresp_val;
  logic                    imemresp_rdy;
  logic [p_data_nbits-1:0] imemresp_msg_data;
  logic                    inst_val_D;
  logic                    inst_rdy_D;
  logic [p_data_nbits-1:0] inst_D;
  logic                    inst_domain_D;
  logic [1:0]              num_inflight;

  modport master (
    input  domain, pc_next_F, fetch_val_F, squash_F, imemreq_rdy,
           imemresp_val, imemresp_msg_data, inst_rdy_D,
    output fetch_rdy_F, imemreq_val, imemreq_msg_addr, imemresp_rdy,
           inst_val_D, inst_D, inst_domain_D, num_inflight
  );

  modport slave (
    output domain, pc_next_F, fetch_val_F, squash_F, imemreq_rdy,
           imemresp_val, imemresp_msg_data, inst_rdy_D,
    input  fetch_rdy_F, imemreq_val, imemreq_msg_addr, imemresp_rdy,
           inst_val_D, inst_D, inst_domain_D, num_inflight
  );
endinterface

// File: rtl/plab2_proc_fetch_unit.sv
// ---------------------------------------------------------------------------
// plab2_proc_fetch_unit
//   Instruction-fetch front end between the F-stage PC logic and the D-stage
//   instruction register. Issues imem requests under a credit limit, tags each
//   request with its security domain, discards responses of squashed fetches
//   and buffers surviving instructions so a D-stage stall never loses one.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous, active-low
//     bus   : plab2_proc_fetch_unit_if.master (F, imem and D interfaces)
// ---------------------------------------------------------------------------
module plab2_proc_fetch_unit #(
  parameter int p_max_outstanding = 2,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32
) (
  input logic                           clk,
  input logic                           reset,
  plab2_proc_fetch_unit_if.master       bus
);

  localparam int DEPTH = p_max_outstanding;
  localparam int CW    = $clog2(p_max_outstanding + 1);
  localparam int PW    = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam logic [CW:0] MAX_C = (CW+1)'(p_max_outstanding);

  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d, t_rd_q, t_rd_d, t_wr_q, t_wr_d;

  logic [p_data_nbits-1:0] q_data_mem [DEPTH];
  logic                    q_dom_mem  [DEPTH];
  logic                    tag_mem    [DEPTH];

  logic credit_ok, req_val, req_fire, resp_ok, squash;
  logic q_empty, enq, bypass, inst_val, deq, q_write, q_pop, tag_head;
  logic [p_data_nbits-1:0] head_data;
  logic                    head_dom;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // Buffered instructions hold credits too, so the queue can never overflow.
    credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < MAX_C;
    req_val   = reset & bus.fetch_val_F & credit_ok;
    req_fire  = req_val & bus.imemreq_rdy;
    // A response with nothing in flight is a protocol error and is ignored.
    resp_ok   = reset & bus.imemresp_val & (inflight_q != '0);
    squash    = reset & bus.squash_F;
    q_empty   = (count_q == '0);
    tag_head  = tag_mem[t_rd_q];
    enq       = resp_ok & (drop_q == '0) & ~squash;
    bypass    = enq & q_empty;
    inst_val  = reset & ~squash & (~q_empty | bypass);
    deq       = inst_val & bus.inst_rdy_D;
    // A bypassed instruction taken by D this cycle never enters the queue.
    q_write   = enq & ~(bypass & bus.inst_rdy_D);
    q_pop     = deq & ~q_empty;
    head_data = q_empty ? bus.imemresp_msg_data : q_data_mem[q_rd_q];
    head_dom  = q_empty ? tag_head : q_dom_mem[q_rd_q];

    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
    // The tag FIFO is never flushed: dropped responses still pop their tag.
    t_wr_d     = req_fire ? ptr_inc(t_wr_q) : t_wr_q;
    t_rd_d     = resp_ok  ? ptr_inc(t_rd_q) : t_rd_q;

    // On a squash every older fetch is dead; a response arriving in the same
    // cycle is one of them, and a request firing now is the redirect target.
    if (squash)
      drop_d = inflight_q - CW'(resp_ok);
    else if (resp_ok && (drop_q != '0))
      drop_d = drop_q - 1'b1;
    else
      drop_d = drop_q;

    if (squash) begin
      count_d = '0;
      q_rd_d  = '0;
      q_wr_d  = '0;
    end else begin
      count_d = count_q + CW'(q_write) - CW'(q_pop);
      q_wr_d  = q_write ? ptr_inc(q_wr_q) : q_wr_q;
      q_rd_d  = q_pop   ? ptr_inc(q_rd_q) : q_rd_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      t_rd_q     <= '0;
      t_wr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      t_rd_q     <= t_rd_d;
      t_wr_q     <= t_wr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire)
      tag_mem[t_wr_q] <= bus.domain;
    if (q_write) begin
      q_data_mem[q_wr_q] <= bus.imemresp_msg_data;
      q_dom_mem[q_wr_q]  <= tag_head;
    end
  end

  assign bus.imemreq_val      = req_val;
  assign bus.fetch_rdy_F      = reset & bus.imemreq_rdy & credit_ok;
  assign bus.imemreq_msg_addr = bus.pc_next_F;
  assign bus.imemresp_rdy     = reset;
  assign bus.inst_val_D       = inst_val;
  assign bus.inst_D           = inst_val ? head_data : '0;
  assign bus.inst_domain_D    = inst_val & head_dom;
  assign bus.num_inflight     = 2'(inflight_q);

endmodule
